pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming PWM waveform and reports its high time and period, counted in `step` ticks. It is the receive-side counterpart to the team's PWM generator: the same `step` prescale, the same N-bit duty scale, and saturating full-off / full-on detection. It sits between an asynchronous PWM input pin and register/telemetry logic that consumes measurements on a one-cycle `valid` strobe.

## Interface
- `N`, default 8: counter width, so the high-time range is 0..2^N-1 ticks.
- `clk` input 1: single clock; all logic on the posedge.
- `rst` input 1: asynchronous, active-high reset.
- `ena` input 1: enables measurement; when low, the FSM is held in IDLE.
- `step` input 1: tick enable; counters advance only on cycles where `step`=1.
- `pwm_in` input 1: asynchronous PWM input.
- `high_time` output N: high-phase length of the last completed measurement, in ticks.
- `period` output N+1: high plus low length of the last measurement, in ticks.
- `valid` output 1: one-cycle strobe when `high_time`/`period`/flags update.
- `stuck_high` output 1: last measurement saturated high.
- `stuck_low` output 1: last measurement saturated low.

## Operation
- Input path: 2-flop synchronizer, then a registered previous-value flop. Rise/fall are detected from sync vs previous.
- Counters `hi_cnt` and `lo_cnt`, each N bits, saturate at 2^N-1 and never wrap.
- On a tick, the counter of the current phase increments.
- On an edge cycle, the new phase's counter loads `step ? 1 : 0`; the edge wins over the tick for the old phase.
- FSM states:
  - IDLE: entered on reset or when `ena`=0. Ignores falls. A rise goes to HIGH with no `valid`. While the sync input is low, `lo_cnt` counts ticks; saturation goes to SAT_LOW.
  - HIGH: a fall goes to LOW. If `hi_cnt` saturates, go to SAT_HIGH.
  - LOW: on a rise, publish and go to HIGH:
    - `high_time`=`hi_cnt`
    - `period`=`hi_cnt`+`lo_cnt`, zero-extended to N+1 bits
    - both flags cleared
    - `valid`=1
    - If `lo_cnt` saturates, go to SAT_LOW.
  - SAT_HIGH: on entry, publish `high_time`=2^N-1, `period`=2^N-1, `stuck_high`=1, `stuck_low`=0, `valid`=1. Stay with no further `valid` until a fall, then go to LOW.
  - SAT_LOW: on entry, publish `high_time`=0, `period`=2^N-1, `stuck_low`=1, `stuck_high`=0, `valid`=1. Stay until a rise, then go to HIGH with no `valid`.
- `ena` falling: go to IDLE next cycle and clear the counters. Outputs hold their last values and `valid` is forced to 0.
- Reset, including mid-measurement: state IDLE, counters 0, synchronizer flops 0, all outputs 0.

## Timing
- `pwm_in` sampled high at clock edge k: the synchronizer output is high after edge k+1, the edge is detected during cycle k+1→k+2, and the FSM transition and `valid` register at edge k+2.
- `valid` is high for exactly one cycle after that edge: 3-cycle latency from the sampling edge, or 5 with the filter enabled.
- Outputs update only on the same edge that asserts `valid`, and are stable between strobes.
- Sampling is every clk, independent of `step`. Phases shorter than 1 clk (3 clk with the filter) may be missed.
- `ena` rising with `pwm_in` already high: the first `valid` comes at the end of the first full period after the next rise.

## Configuration
- `PWM_CAPTURE_GLITCH_FILTER_EN` defined: after the synchronizer, a level is accepted only once it has been stable for 3 consecutive clks. Adds 2 clks of latency, and pulses shorter than 3 clks are ignored.
- `PWM_CAPTURE_GLITCH_FILTER_EN` undefined: the synchronizer output is used directly, with no filter logic.

## Test plan
All cases use N=8 and `step`=1 every cycle unless stated otherwise.
- Reset: assert `rst` asynchronously mid-HIGH -> all outputs 0 immediately, FSM IDLE; first `valid` only after one full rise-to-rise period.
- Nominal: `pwm_in` high 40 clk / low 60 clk repeating -> `high_time`=40, `period`=100, one `valid` per 100 clk, 3 clk after each sampled rise.
- Prescale: `step` every 4th clk, waveform 64/192 ticks (256/768 clk) -> `high_time`=64, `period`=256.
- Saturation high: hold `pwm_in`=1 for 300 clk -> a single `valid` with `high_time`=255, `period`=255, `stuck_high`=1. A later 10/20 waveform clears `stuck_high` and reports 10/30.
- Saturation low and `ena`: hold `pwm_in`=0 from IDLE -> `valid` after 255 ticks with `high_time`=0, `stuck_low`=1. Dropping `ena` mid-period -> no `valid`, outputs hold.
- Filter build: a 2-clk high glitch in the low phase of a 40/60 waveform -> reports 40/100 with `PWM_CAPTURE_GLITCH_FILTER_EN` defined; splits the measurement without it.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time and period in step ticks with saturating stuck detection.
// Build option PWM_CAPTURE_GLITCH_FILTER_EN inserts a 3-clk stability filter after the synchronizer.
module pwm_capture #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic         pwm_in,
    output logic [N-1:0] high_time,
    output logic [N:0]   period,
    output logic         valid,
    output logic         stuck_high,
    output logic         stuck_low
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HIGH     = 3'd1,
        S_LOW      = 3'd2,
        S_SAT_HIGH = 3'd3,
        S_SAT_LOW  = 3'd4
    } state_t;

    localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
    localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic         sync1_q, sync2_q, prev_q;
    logic         lvl_s, rise_s, fall_s;
    logic [N-1:0] step_cnt_s;
    logic [N-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
    logic [N-1:0] high_time_q, high_time_d;
    logic [N:0]   period_q, period_d;
    logic         valid_q, valid_d;
    logic         stuck_high_q, stuck_high_d;
    logic         stuck_low_q, stuck_low_d;

    // Two-flop synchronizer plus the previous accepted level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= lvl_s;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist_q;

    // Two older synchronizer samples; the level only moves once all three agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    // Accept the synchronized level only after three consecutive equal samples.
    always_comb begin
        if ((sync2_q == hist_q[0]) && (hist_q[0] == hist_q[1])) begin
            lvl_s = sync2_q;
        end else begin
            lvl_s = prev_q;
        end
    end
`else
    assign lvl_s = sync2_q;
`endif

    assign rise_s     = lvl_s & ~prev_q;
    assign fall_s     = ~lvl_s & prev_q;
    assign step_cnt_s = {{(N-1){1'b0}}, step};

    // Phase counters, FSM next state and the measurement published with valid.
    always_comb begin
        state_d      = state_q;
        high_time_d  = high_time_q;
        period_d     = period_q;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;
        valid_d      = 1'b0;
        hi_cnt_d     = hi_cnt_q;
        lo_cnt_d     = lo_cnt_q;

        if (!ena) begin
            state_d  = S_IDLE;
            hi_cnt_d = CNT_ZERO;
            lo_cnt_d = CNT_ZERO;
        end else begin
            // An edge reloads the new phase; the old phase does not take the tick.
            if (rise_s) begin
                hi_cnt_d = step_cnt_s;
            end else if (lvl_s && step && (hi_cnt_q != CNT_MAX)) begin
                hi_cnt_d = hi_cnt_q + CNT_ONE;
            end else begin
                hi_cnt_d = hi_cnt_q;
            end
            if (fall_s) begin
                lo_cnt_d = step_cnt_s;
            end else if (!lvl_s && step && (lo_cnt_q != CNT_MAX)) begin
                lo_cnt_d = lo_cnt_q + CNT_ONE;
            end else begin
                lo_cnt_d = lo_cnt_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (rise_s) begin
                        state_d = S_HIGH;
                    end else if (!lvl_s && (lo_cnt_q == CNT_MAX)) begin
                        state_d      = S_SAT_LOW;
                        high_time_d  = CNT_ZERO;
                        period_d     = {1'b0, CNT_MAX};
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b1;
                        valid_d      = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HIGH: begin
                    if (fall_s) begin
                        state_d = S_LOW;
                    end else if (hi_cnt_q == CNT_MAX) begin
                        state_d      = S_SAT_HIGH;
                        high_time_d  = CNT_MAX;
                        period_d     = {1'b0, CNT_MAX};
                        stuck_high_d = 1'b1;
                        stuck_low_d  = 1'b0;
                        valid_d      = 1'b1;
                    end else begin
                        state_d = S_HIGH;
                    end
                end
                S_LOW: begin
                    if (rise_s) begin
                        state_d      = S_HIGH;
                        high_time_d  = hi_cnt_q;
                        period_d     = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b0;
                        valid_d      = 1'b1;
                    end else if (lo_cnt_q == CNT_MAX) begin
                        state_d      = S_SAT_LOW;
                        high_time_d  = CNT_ZERO;
                        period_d     = {1'b0, CNT_MAX};
                        stuck_high_d = 1'b0;
                        stuck_low_d  = 1'b1;
                        valid_d      = 1'b1;
                    end else begin
                        state_d = S_LOW;
                    end
                end
                S_SAT_HIGH: begin
                    if (fall_s) begin
                        state_d = S_LOW;
                    end else begin
                        state_d = S_SAT_HIGH;
                    end
                end
                S_SAT_LOW: begin
                    if (rise_s) begin
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_SAT_LOW;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hi_cnt_q     <= CNT_ZERO;
            lo_cnt_q     <= CNT_ZERO;
            high_time_q  <= CNT_ZERO;
            period_q     <= {(N+1){1'b0}};
            valid_q      <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            high_time_q  <= high_time_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign high_time  = high_time_q;
    assign period     = period_q;
    assign valid      = valid_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: per-cycle comparison against a behavioural model plus directed literals.
module tb_pwm_capture;
    localparam int N = 8;
    localparam int MAXC = 255;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT_EXP = 5;
`else
    localparam int LAT_EXP = 3;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         step;
    logic         pwm_in;
    logic [N-1:0] high_time;
    logic [N:0]   period;
    logic         valid;
    logic         stuck_high;
    logic         stuck_low;

    int errors = 0;
    int checks = 0;

    pwm_capture #(.N(N)) dut (
        .clk(clk), .rst(rst), .ena(ena), .step(step), .pwm_in(pwm_in),
        .high_time(high_time), .period(period), .valid(valid),
        .stuck_high(stuck_high), .stuck_low(stuck_low)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the FSM sees pwm_in two samples late; phases are measured in ticks.
    int m_mode;      // 0 idle, 1 high, 2 low, 3 stuck high, 4 stuck low
    int m_hi, m_lo;
    bit m_prev;
    bit smp[4];
    int e_ht, e_per;
    bit e_v, e_sh, e_sl;

    task automatic publish(input int ht, input int per, input bit sh, input bit sl);
        e_ht = ht; e_per = per; e_sh = sh; e_sl = sl; e_v = 1'b1;
    endtask

    initial begin
        bit lvl, rise, fall;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = 0; m_hi = 0; m_lo = 0; m_prev = 0;
                for (int i = 0; i < 4; i++) smp[i] = 0;
                e_ht = 0; e_per = 0; e_v = 0; e_sh = 0; e_sl = 0;
            end else begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
                lvl = (smp[1] == smp[2] && smp[2] == smp[3]) ? smp[1] : m_prev;
`else
                lvl = smp[1];
`endif
                rise = lvl && !m_prev;
                fall = !lvl && m_prev;
                e_v = 1'b0;
                if (!ena) begin
                    m_mode = 0; m_hi = 0; m_lo = 0;
                end else begin
                    case (m_mode)
                        0: if (rise) m_mode = 1;
                           else if (!lvl && m_lo == MAXC) begin m_mode = 4; publish(0, MAXC, 0, 1); end
                        1: if (fall) m_mode = 2;
                           else if (m_hi == MAXC) begin m_mode = 3; publish(MAXC, MAXC, 1, 0); end
                        2: if (rise) begin m_mode = 1; publish(m_hi, m_hi + m_lo, 0, 0); end
                           else if (m_lo == MAXC) begin m_mode = 4; publish(0, MAXC, 0, 1); end
                        3: if (fall) m_mode = 2;
                        4: if (rise) m_mode = 1;
                        default: m_mode = 0;
                    endcase
                    if (rise) m_hi = step;
                    else if (lvl && step && m_hi < MAXC) m_hi = m_hi + 1;
                    if (fall) m_lo = step;
                    else if (!lvl && step && m_lo < MAXC) m_lo = m_lo + 1;
                end
                m_prev = lvl;
                smp[3] = smp[2]; smp[2] = smp[1]; smp[1] = smp[0]; smp[0] = pwm_in;
            end
        end
    end

    // Per-cycle compare against the model, plus a record of each strobe for directed checks.
    int nval = 0;
    int last_ht, last_per;
    bit last_sh, last_sl;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("cyc_valid", valid, e_v);
                chk("cyc_high_time", high_time, e_ht);
                chk("cyc_period", period, e_per);
                chk("cyc_stuck_high", stuck_high, e_sh);
                chk("cyc_stuck_low", stuck_low, e_sl);
                if (valid) begin
                    nval++;
                    last_ht = high_time; last_per = period;
                    last_sh = stuck_high; last_sl = stuck_low;
                end
            end
        end
    end

    bit prescale = 1'b0;
    int tick_ctr = 0;

    task automatic hold(input bit level, input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in = level;
            step = prescale ? (tick_ctr % 4 == 0) : 1'b1;
            tick_ctr++;
        end
    endtask

    initial begin
        int n0, lat;
        rst = 1'b1; ena = 1'b1; step = 1'b1; pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_high_time", high_time, 0);
        chk("reset_period", period, 0);
        chk("reset_valid", valid, 0);
        chk("reset_flags", {stuck_high, stuck_low}, 0);
        rst = 1'b0;

        // Nominal 40/60
        hold(0, 10);
        n0 = nval;
        repeat (4) begin hold(1, 40); hold(0, 60); end
        chk("nominal_count", nval - n0, 3);
        chk("nominal_high", last_ht, 40);
        chk("nominal_period", last_per, 100);
        @(negedge clk); pwm_in = 1'b1; step = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (valid && lat == 0) lat = i;
        end
        chk("rise_latency", lat, LAT_EXP);
        hold(1, 31); hold(0, 60);

        // Asynchronous reset mid-high
        hold(1, 20);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_high_time", high_time, 0);
        chk("rst_async_period", period, 0);
        chk("rst_async_valid", valid, 0);
        hold(1, 10); hold(0, 5);
        rst = 1'b0;
        n0 = nval;
        hold(0, 55); hold(1, 40); hold(0, 60);
        chk("rst_no_early_valid", nval - n0, 0);
        hold(1, 8);
        chk("rst_first_valid", nval - n0, 1);
        chk("rst_first_high", last_ht, 40);
        chk("rst_first_period", last_per, 100);

        // Prescale: one tick per 4 clk
        prescale = 1'b1;
        hold(1, 32); hold(0, 768);
        repeat (2) begin hold(1, 256); hold(0, 768); end
        hold(1, 8);
        chk("prescale_high", last_ht, 64);
        chk("prescale_period", last_per, 256);
        prescale = 1'b0;

        // Saturation high, then recovery with 10/20
        n0 = nval;
        hold(1, 300);
        chk("sat_high_count", nval - n0, 1);
        chk("sat_high_values", {last_ht, last_per}, {32'd255, 32'd255});
        chk("sat_high_flags", {last_sh, last_sl}, 2'b10);
        hold(0, 20);
        repeat (3) begin hold(1, 10); hold(0, 20); end
        hold(1, 5);
        chk("recover_high", last_ht, 10);
        chk("recover_period", last_per, 30);
        chk("recover_flags", {last_sh, last_sl}, 2'b00);

        // Saturation low from idle
        hold(0, 20);
        ena = 1'b0;
        hold(0, 5);
        ena = 1'b1;
        n0 = nval;
        hold(0, 300);
        chk("sat_low_count", nval - n0, 1);
        chk("sat_low_values", {last_ht, last_per}, {32'd0, 32'd255});
        chk("sat_low_flags", {last_sh, last_sl}, 2'b01);

        // Dropping ena mid-period: no strobe, outputs hold
        n0 = nval;
        hold(1, 40); hold(0, 30);
        ena = 1'b0;
        hold(0, 30); hold(1, 40); hold(0, 60);
        chk("ena_low_no_valid", nval - n0, 0);
        chk("ena_low_hold_values", {high_time, period}, {8'd0, 9'd255});
        chk("ena_low_hold_flags", {stuck_high, stuck_low}, 2'b01);

        // Glitch in the low phase
        ena = 1'b1;
        hold(0, 10); hold(1, 40); hold(0, 60); hold(1, 40);
        n0 = nval;
        hold(0, 20); hold(1, 2); hold(0, 38); hold(1, 8);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        chk("glitch_count", nval - n0, 1);
        chk("glitch_high", last_ht, 40);
        chk("glitch_period", last_per, 100);
`else
        chk("glitch_count", nval - n0, 2);
        chk("glitch_high", last_ht, 2);
        chk("glitch_period", last_per, 40);
`endif
        hold(0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
